// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pipeline_pkg;

  localparam int PC_W = 30;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RESET,
    FETCH,
    HOLD,
    DISCARD
  } fetch_state_t;

  // IF/ID payload: fetched instruction and the address after it.
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_plus1;
  } ifid_t;

  // Word-address increment; wraps 30'h3FFF_FFFF to 0.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_skid_buf.sv
// One-entry skid buffer that catches an instruction returned while the
// pipeline is stalled.
module pipeline_skid_buf
  import pipeline_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_load,
  input  logic  i_drain,
  input  logic  i_clear,
  input  ifid_t i_data,
  output ifid_t o_data,
  output logic  o_full
);

  ifid_t data_q;
  logic  full_q;

  // Occupancy: reset/clear win over load, load wins over drain.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      full_q <= 1'b0;
    end else if (i_load) begin
      full_q <= 1'b1;
    end else if (i_drain) begin
      full_q <= 1'b0;
    end
  end

  // Payload capture.
  // NOTE: the payload is only ever read while full_q is set, so it carries
  // no reset; only the flag that qualifies it must be reset.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      data_q <= i_data;
    end
  end

  assign o_data = data_q;
  assign o_full = full_q;

endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, imem request/ack handshake,
// IF/ID register, stall skid buffer and wrong-path flush.
module pipeline_fetch_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_PCSrc,
  input  logic [PC_W-1:0] i_PC_target,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_PC_plus1,
  output logic            o_valid,
  output logic [15:0]     o_flush_cnt
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] disc_addr_q, disc_addr_d;
  ifid_t           ifid_q, ifid_d;
  logic            valid_q, valid_d;
  logic [15:0]     flush_cnt_q, flush_cnt_d;

  logic            redirect;
  logic            skid_load, skid_drain, skid_clear, skid_full;
  ifid_t           skid_in, skid_data;

  assign redirect = i_PCSrc & ~i_stall;
  assign skid_in  = '{instr: i_imem_rdata, pc_plus1: pc_inc(pc_q)};

  pipeline_skid_buf u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (skid_load),
    .i_drain (skid_drain),
    .i_clear (skid_clear),
    .i_data  (skid_in),
    .o_data  (skid_data),
    .o_full  (skid_full)
  );

  // Next-state and next-register logic; redirect beats stall beats ack.
  // NOTE: every target gets a default before the case so no path can leave
  // it unassigned (which would infer a latch); combinational logic uses
  // blocking '=' while the register block below uses '<='.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    disc_addr_d = disc_addr_q;
    ifid_d      = ifid_q;
    valid_d     = valid_q;
    flush_cnt_d = flush_cnt_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      pc_d       = i_PC_target;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    case (state_q)
      RESET: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          // An unacknowledged request must still finish at the old address.
          if (!i_imem_ack) begin
            disc_addr_d = pc_q;
            state_d     = DISCARD;
          end
        end else if (i_stall) begin
          if (i_imem_ack) begin
            skid_load = 1'b1;
            pc_d      = pc_inc(pc_q);
            state_d   = HOLD;
          end
        end else if (i_imem_ack) begin
          ifid_d  = skid_in;
          valid_d = 1'b1;
          pc_d    = pc_inc(pc_q);
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = FETCH;
        end else if (!i_stall && skid_full) begin
          ifid_d     = skid_data;
          valid_d    = 1'b1;
          skid_drain = 1'b1;
          state_d    = FETCH;
        end
      end
      DISCARD: begin
        // Wrong-path data is dropped; PC already holds the latest target.
        if (i_imem_ack) state_d = FETCH;
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RESET;
      pc_q        <= RESET_PC;
      disc_addr_q <= '0;
      ifid_q      <= '0;
      valid_q     <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      disc_addr_q <= disc_addr_d;
      ifid_q      <= ifid_d;
      valid_q     <= valid_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_imem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign o_imem_addr = (state_q == DISCARD) ? disc_addr_q : pc_q;
  assign o_instr     = valid_q ? ifid_q.instr : NOP;
  assign o_PC_plus1  = ifid_q.pc_plus1;
  assign o_valid     = valid_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule
